// File: rtl/seg7_scan.sv
// seg7_scan: shows a 12-bit binary value as a 4-digit decimal number on a
// multiplexed common-anode 7-segment display.
// A sequential shift-add-3 engine converts the value to BCD. The result is
// committed to the display register in a single cycle, so the display never
// shows a mix of old and new digits. The anodes are time-multiplexed from a
// programmable scan divider.
//
// Build option: define SEG7_LZB_EN to blank leading zeros. Digit 0 is never
// blanked.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   value      binary value to display (0..4095)
//   an         digit anodes, active-low; an[0] is the units digit
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low; always off
//   conv_busy  high while a conversion is in progress
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        conv_busy
);

    localparam int unsigned BIN_W  = 12;
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state, state_nx;
    logic [BIN_W-1:0]   last, last_nx;
    logic [BIN_W-1:0]   sh, sh_nx;
    logic [BCD_W-1:0]   bcd, bcd_nx, bcd_adj;
    logic [BCD_W-1:0]   disp, disp_nx;
    logic [3:0]         cnt, cnt_nx;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         idx;
    logic [3:0]         digit;
    logic               blank;

    // Add-3 correction for every BCD nibble that is 5 or more, applied before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Conversion state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= '0;
            sh    <= '0;
            bcd   <= '0;
            disp  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            sh    <= sh_nx;
            bcd   <= bcd_nx;
            disp  <= disp_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nx = state;
        last_nx  = last;
        sh_nx    = sh;
        bcd_nx   = bcd;
        disp_nx  = disp;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (value != last) begin
                    sh_nx    = value;
                    bcd_nx   = '0;
                    cnt_nx   = '0;
                    last_nx  = value;
                    state_nx = CONV;
                end
            end
            CONV: begin
                {bcd_nx, sh_nx} = {bcd_adj, sh} << 1;
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd11)
                    state_nx = DONE;
            end
            DONE: begin
                disp_nx  = bcd;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Scan divider: each digit stays lit for SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Leading-zero detection for the currently lit digit
    always_comb begin
        blank = 1'b0;
`ifdef SEG7_LZB_EN
        unique case (idx)
            2'd3:    blank = (disp[15:12] == 4'd0);
            2'd2:    blank = (disp[15:8]  == 8'd0);
            2'd1:    blank = (disp[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
`endif
    end

    // Anode and segment decode from registered idx/disp
    always_comb begin
        digit = disp[{idx, 2'b00} +: 4];
        an    = ~(4'b0001 << idx);
        seg   = 7'b1111111;
        if (!blank) begin
            unique case (digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end

    assign dp        = 1'b1;
    assign conv_busy = (state != IDLE);

endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan (SCAN_DIV = 4). A behavioural model tracks the
// displayed value as an integer, how many busy cycles remain, and how many
// cycles have elapsed since reset. The expected digits come from decimal
// arithmetic on that integer.
module tb_seg7_scan;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] value = 12'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        conv_busy;

    int vectors = 0;
    int miscompares = 0;

    seg7_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .conv_busy (conv_busy)
    );

    always #5 clk = ~clk;

    // Reference model: a change seen while not busy gives 13 busy cycles, then the new value is shown
    int m_last = 0, m_disp = 0, m_pend = 0, m_left = 0, m_scan = 0;
    always @(posedge clk) begin
        if (reset) begin
            m_last <= 0; m_disp <= 0; m_pend <= 0; m_left <= 0; m_scan <= 0;
        end else begin
            m_scan <= m_scan + 1;
            if (m_left == 0) begin
                if (int'(value) != m_last) begin
                    m_last <= int'(value);
                    m_pend <= int'(value);
                    m_left <= 13;
                end
            end else begin
                if (m_left == 1) m_disp <= m_pend;
                m_left <= m_left - 1;
            end
        end
    end

    function automatic int pow10(int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] seg_code(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(int v, int i);
`ifdef SEG7_LZB_EN
        if (i > 0 && v < pow10(i)) return 7'b1111111;
`endif
        return seg_code((v / pow10(i)) % 10);
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int exp_idx();
        return (m_scan / int'(SCAN_DIV)) % 4;
    endfunction

    task automatic test_reset();
        reset = 1'b1; value = 12'd0;
        repeat (2) @(negedge clk);
        vectors++;
        if (an !== 4'b1110 || seg !== 7'b1000000 || conv_busy !== 1'b0 || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: an=%b seg=%b busy=%b dp=%b, want 1110 1000000 0 1", an, seg, conv_busy, dp);
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (conv_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle_busy cycle %0d: busy=%b want 0", c, conv_busy);
            end
        end
    endtask

    task automatic test_latency();
        value = 12'd4095;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            vectors++;
            if (conv_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL latency_busy after edge N+%0d: busy=%b want 1", c, conv_busy);
            end
        end
        @(negedge clk);
        vectors++;
        if (conv_busy !== 1'b0 || dut.disp !== 16'h4095) begin
            miscompares++;
            $display("FAIL latency_commit: busy=%b disp=%h want 0 4095", conv_busy, dut.disp);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            vectors++;
            if (seg !== exp_seg(4095, exp_idx())) begin
                miscompares++;
                $display("FAIL latency_seg digit %0d: seg=%b want %b", exp_idx(), seg, exp_seg(4095, exp_idx()));
            end
        end
    endtask

    task automatic test_mid_change();
        value = 12'd123;
        repeat (3) @(negedge clk);
        value = 12'd7;
        repeat (10) @(negedge clk);
        vectors++;
        if (dut.disp !== 16'h4095 || conv_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_before_commit: disp=%h busy=%b want 4095 1", dut.disp, conv_busy);
        end
        @(negedge clk);
        vectors++;
        if (dut.disp !== 16'h0123 || conv_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_first_commit: disp=%h busy=%b want 0123 0", dut.disp, conv_busy);
        end
        @(negedge clk);
        vectors++;
        if (conv_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_second_start: busy=%b want 1", conv_busy);
        end
        repeat (12) @(negedge clk);
        vectors++;
        if (dut.disp !== 16'h0123) begin
            miscompares++;
            $display("FAIL mid_second_early: disp=%h want 0123", dut.disp);
        end
        @(negedge clk);
        vectors++;
        if (dut.disp !== 16'h0007 || conv_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_second_commit: disp=%h busy=%b want 0007 0", dut.disp, conv_busy);
        end
    endtask

    task automatic test_scan_wrap();
        value = 12'd1234;
        repeat (14) @(negedge clk);
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            vectors++;
            if (an !== ~(4'b0001 << exp_idx()) || seg !== exp_seg(1234, exp_idx())) begin
                miscompares++;
                $display("FAIL scan_wrap cycle %0d: an=%b seg=%b want %b %b", c, an, seg,
                         ~(4'b0001 << exp_idx()), exp_seg(1234, exp_idx()));
            end
        end
    endtask

    task automatic test_blanking();
        value = 12'd42;
        repeat (14) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            vectors++;
            if (an !== ~(4'b0001 << exp_idx()) || seg !== exp_seg(42, exp_idx())) begin
                miscompares++;
                $display("FAIL blanking digit %0d: an=%b seg=%b want seg %b", exp_idx(), an, seg, exp_seg(42, exp_idx()));
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        value = 12'd999;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (conv_busy !== 1'b0 || dut.disp !== 16'h0000 || an !== 4'b1110 || seg !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_mid_conv: busy=%b disp=%h an=%b seg=%b want 0 0000 1110 1000000",
                     conv_busy, dut.disp, an, seg);
        end
        reset = 1'b0;
        repeat (14) @(negedge clk);
        vectors++;
        if (dut.disp !== 16'h0999 || conv_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_reconvert: disp=%h busy=%b want 0999 0", dut.disp, conv_busy);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int hold;
            value = 12'($urandom_range(0, 4095));
            hold = int'($urandom_range(1, 20));
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                vectors++;
                if (conv_busy !== (m_left > 0) || dut.disp !== to_bcd(m_disp) ||
                    an !== ~(4'b0001 << exp_idx()) || seg !== exp_seg(m_disp, exp_idx())) begin
                    miscompares++;
                    $display("FAIL random it %0d: busy=%b disp=%h an=%b seg=%b want %b %h %b %b", it,
                             conv_busy, dut.disp, an, seg, (m_left > 0), to_bcd(m_disp),
                             ~(4'b0001 << exp_idx()), exp_seg(m_disp, exp_idx()));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_mid_change();
        test_scan_wrap();
        test_blanking();
        test_reset_mid_conv();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
